// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: blank/dash patterns and the
// active-low {a,b,c,d,e,f,g} decode table.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h7E;

  // Entry i is the pattern for code i; the first element listed is code 15.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08,   // F E d C b A
    7'h04, 7'h00, 7'h0F, 7'h20, 7'h24, 7'h4C,   // 9 8 7 6 5 4
    7'h06, 7'h12, 7'h4F, 7'h01                  // 3 2 1 0
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] code, input logic hex_en);
    logic [6:0] seg;
    seg = SEG_LUT[code];
    if (!hex_en && (code > 4'd9)) begin
      seg = SEG_DASH;
    end
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Datapath-facing load bus plus the board-facing display pins of the scan driver.
// The datapath side is master; the driver is slave.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;

  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    upd_pulse;

  modport master (
    output load, digits_in, dp_in, blank_lz,
    input  seg_n, dp_n, an_n, upd_pulse
  );

  modport slave (
    input  load, digits_in, dp_in, blank_lz,
    output seg_n, dp_n, an_n, upd_pulse
  );

endinterface

// File: rtl/seg7_scan_driver_decode.sv
// Combinational hex/BCD to active-low segment decoder; never produces X.
// Codes 10-15 show letters when HEX_EN is set, otherwise a dash.
module seg7_scan_driver_decode
  import seg7_scan_driver_pkg::*;
#(
  parameter bit HEX_EN = 1'b1
) (
  input  logic [3:0] i_code,
  output logic [6:0] o_seg_n
);

  assign o_seg_n = seg_lookup(i_code, HEX_EN);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with shadow/display
// double buffering (commits only at frame end) and a registered pin stage.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 2,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]      r_div_cnt;
  logic [IDX_W-1:0]      r_idx;

  logic [DW-1:0]         r_shadow_dig;
  logic [NUM_DIGITS-1:0] r_shadow_dp;
  logic                  r_shadow_lz;
  logic                  r_pending;

  logic [DW-1:0]         r_disp_dig;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic                  r_disp_lz;

  logic [6:0]            r_seg_n;
  logic                  r_dp_n;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic                  r_upd_pulse;

  logic                  w_tick;
  logic                  w_frame_end;
  logic                  w_active;
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_lz_blank;
  logic [3:0]            w_code;
  logic                  w_dp;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_an_sel;
  logic [6:0]            w_dec_seg_n;

  assign w_tick      = (r_div_cnt == DIV_LAST);
  assign w_frame_end = w_tick && (r_idx == IDX_LAST);
  assign w_active    = (r_div_cnt >= BLANK_END);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // A load on the frame-end edge is captured while the older shadow commits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow_dig <= '0;
      r_shadow_dp  <= '0;
      r_shadow_lz  <= 1'b0;
      r_pending    <= 1'b0;
      r_disp_dig   <= '0;
      r_disp_dp    <= '0;
      r_disp_lz    <= 1'b0;
      r_upd_pulse  <= 1'b0;
    end else begin
      if (bus.load) begin
        r_shadow_dig <= bus.digits_in;
        r_shadow_dp  <= bus.dp_in;
        r_shadow_lz  <= bus.blank_lz;
      end
      if (w_frame_end && r_pending) begin
        r_disp_dig <= r_shadow_dig;
        r_disp_dp  <= r_shadow_dp;
        r_disp_lz  <= r_shadow_lz;
      end
      r_pending   <= bus.load | (r_pending & ~w_frame_end);
      r_upd_pulse <= w_frame_end & r_pending;
    end
  end

  // Digit k is a leading zero when it and every digit to its left are zero.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run    = w_zero_run & (r_disp_dig[4*k +: 4] == 4'h0);
      w_lz_blank[k] = r_disp_lz & w_zero_run & (k != 0);
    end
  end

  always_comb begin
    w_code   = 4'h0;
    w_dp     = 1'b0;
    w_blank  = 1'b0;
    w_an_sel = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_code      = r_disp_dig[4*k +: 4];
        w_dp        = r_disp_dp[k];
        w_blank     = w_lz_blank[k];
        w_an_sel[k] = 1'b0;
      end
    end
  end

  seg7_scan_driver_decode #(
    .HEX_EN (HEX_EN)
  ) u_decode (
    .i_code  (w_code),
    .o_seg_n (w_dec_seg_n)
  );

  // Blanked digits keep their anode on so every slot has the same duty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg_n <= SEG_OFF;
      r_dp_n  <= 1'b1;
      r_an_n  <= '1;
    end else if (w_active) begin
      r_seg_n <= w_blank ? SEG_OFF : w_dec_seg_n;
      r_dp_n  <= ~w_dp;
      r_an_n  <= w_an_sel;
    end else begin
      r_seg_n <= SEG_OFF;
      r_dp_n  <= 1'b1;
      r_an_n  <= '1;
    end
  end

  assign bus.seg_n     = r_seg_n;
  assign bus.dp_n      = r_dp_n;
  assign bus.an_n      = r_an_n;
  assign bus.upd_pulse = r_upd_pulse;

endmodule
